btn_pulse_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_debounce_channel.sv | 144 ++++++++++++++
 rtl/btn_pulse_conditioner.sv | 45 ++++
 tb/tb_btn_pulse_conditioner.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Optional auto-repeat is enabled by defining BTN_REPEAT_EN.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 20 ms stability window, 500 ms to first repeat, 100 ms between repeats at 100 MHz.
  localparam int STABLE_CYCLES_DEF = 2_000_000;
  localparam int REPEAT_DELAY_DEF  = 50_000_000;
  localparam int REPEAT_PERIOD_DEF = 10_000_000;

endpackage : btn_pkg

// File: rtl/btn_debounce_channel.sv
// One button channel: 2-FF synchronizer, stability-count debounce FSM, one-cycle press pulse.
// Defining BTN_REPEAT_EN adds auto-repeat pulses while the button stays pressed.
module btn_debounce_channel
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse,
  output logic held
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("btn_debounce_channel: STABLE_CYCLES must be at least 1");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
    $error("btn_debounce_channel: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end

  logic             s1_q;
  logic             s2_q;
  btn_state_t       state_q;
  btn_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;
  logic             rep_fire;
  logic             pulse_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse s1/s2 into one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A high sample here is release bounce: go back without a new pulse.
        if (s2_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= accept | rep_fire;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int                RCNT_W     = $clog2(REPEAT_DELAY + 1);
  localparam logic [RCNT_W-1:0] REP_LAST   = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] REP_RELOAD = RCNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RCNT_W-1:0] rep_q;
  logic [RCNT_W-1:0] rep_d;

  // Counts only while the button stays pressed; reloading to DELAY-PERIOD
  // makes later repeats arrive every REPEAT_PERIOD cycles.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (state_q == PRESSED && s2_q) begin
      if (rep_q == REP_LAST) begin
        rep_fire = 1'b1;
        rep_d    = REP_RELOAD;
      end else begin
        rep_d = rep_q + RCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign pulse = pulse_q;
  assign held  = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule : btn_debounce_channel

// File: rtl/btn_pulse_conditioner.sv
// Conditions the left/right push-buttons into one-cycle step pulses for the control unit.
// Defining BTN_REPEAT_EN adds auto-repeat pulses on a held button.
module btn_pulse_conditioner
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btnL_raw,
  input  logic btnR_raw,
  output logic leftBtnDebounce,
  output logic rightBtnDebounce,
  output logic btnL_held,
  output logic btnR_held
);

  // The channels share nothing, so simultaneous presses pulse in the same cycle.
  btn_debounce_channel #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_left (
    .clk  (clk),
    .reset(reset),
    .raw  (btnL_raw),
    .pulse(leftBtnDebounce),
    .held (btnL_held)
  );

  btn_debounce_channel #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_right (
    .clk  (clk),
    .reset(reset),
    .raw  (btnR_raw),
    .pulse(rightBtnDebounce),
    .held (btnR_held)
  );

endmodule : btn_pulse_conditioner

// File: tb/tb_btn_pulse_conditioner.sv
// Directed bench for btn_pulse_conditioner: expected pulse edges are queued when
// stimulus is driven and compared every cycle by a negedge monitor.
module tb_btn_pulse_conditioner;

  localparam int STABLE = 4;
  localparam int RDELAY = 12;
  localparam int RPER   = 5;
  localparam int LAT    = STABLE + 2;

  logic clk = 1'b0;
  logic reset;
  logic btnL_raw;
  logic btnR_raw;
  logic leftBtnDebounce;
  logic rightBtnDebounce;
  logic btnL_held;
  logic btnR_held;

  int edge_n   = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  int q_left[$];
  int q_right[$];
  logic exp_l;
  logic exp_r;

  btn_pulse_conditioner #(
    .STABLE_CYCLES(STABLE),
    .REPEAT_DELAY (RDELAY),
    .REPEAT_PERIOD(RPER)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .btnL_raw        (btnL_raw),
    .btnR_raw        (btnR_raw),
    .leftBtnDebounce (leftBtnDebounce),
    .rightBtnDebounce(rightBtnDebounce),
    .btnL_held       (btnL_held),
    .btnR_held       (btnR_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  // Returns just after the falling edge that follows posedge n; inputs driven
  // here are first sampled at posedge n+1.
  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
    #1;
  endtask

  // Scoreboard: a pulse is expected exactly when the queue head names this edge.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_l = (q_left.size() > 0) && (q_left[0] == edge_n);
      exp_r = (q_right.size() > 0) && (q_right[0] == edge_n);
      check("left_pulse", leftBtnDebounce, exp_l);
      check("right_pulse", rightBtnDebounce, exp_r);
      if (exp_l) void'(q_left.pop_front());
      if (exp_r) void'(q_right.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    btnL_raw = 1'b0;
    btnR_raw = 1'b0;

    // Reset state after two reset edges.
    wait_edge(2);
    check("rst_left_pulse", leftBtnDebounce, 1'b0);
    check("rst_right_pulse", rightBtnDebounce, 1'b0);
    check("rst_left_held", btnL_held, 1'b0);
    check("rst_right_held", btnR_held, 1'b0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Clean press: first sampled at edge 10, pulse after edge 16.
    wait_edge(9);
    btnL_raw = 1'b1;
    q_left.push_back(10 + LAT);
    wait_edge(15);
    check("clean_held_before", btnL_held, 1'b0);
    wait_edge(16);
    check("clean_held_after", btnL_held, 1'b1);
    check("clean_right_idle", btnR_held, 1'b0);

    // Release: first low sample at 21, IDLE after 27.
    wait_edge(20);
    btnL_raw = 1'b0;
    wait_edge(26);
    check("release_held_last", btnL_held, 1'b1);
    wait_edge(27);
    check("release_held_clear", btnL_held, 1'b0);

    // Press bounce 1,0,1,0 then held; last rising sample at edge 35.
    wait_edge(30); btnL_raw = 1'b1;
    wait_edge(31); btnL_raw = 1'b0;
    wait_edge(32); btnL_raw = 1'b1;
    wait_edge(33); btnL_raw = 1'b0;
    wait_edge(34); btnL_raw = 1'b1;
    q_left.push_back(35 + LAT);
    wait_edge(38);
    check("bounce_not_held", btnL_held, 1'b0);
    wait_edge(41);
    check("bounce_held", btnL_held, 1'b1);

    // Release bounce: two low samples then high again; held never drops.
    wait_edge(44); btnL_raw = 1'b0;
    wait_edge(46); btnL_raw = 1'b1;
    for (int i = 47; i <= 52; i++) begin
      wait_edge(i);
      check("rel_bounce_held", btnL_held, 1'b1);
    end

    // Full release then one fresh press.
    wait_edge(55); btnL_raw = 1'b0;
    wait_edge(61);
    check("full_release_last", btnL_held, 1'b1);
    wait_edge(62);
    check("full_release_clear", btnL_held, 1'b0);
    wait_edge(65); btnL_raw = 1'b1;
    q_left.push_back(66 + LAT);
    wait_edge(72);
    check("repress_held", btnL_held, 1'b1);
    wait_edge(75); btnL_raw = 1'b0;

    // Simultaneous press on both buttons.
    wait_edge(85);
    btnL_raw = 1'b1;
    btnR_raw = 1'b1;
    q_left.push_back(86 + LAT);
    q_right.push_back(86 + LAT);
    wait_edge(92);
    check("simul_left_held", btnL_held, 1'b1);
    check("simul_right_held", btnR_held, 1'b1);
    wait_edge(95);
    btnL_raw = 1'b0;
    btnR_raw = 1'b0;

    // Reset during PRESS_WAIT with the button held; re-debounced after release.
    wait_edge(105); btnL_raw = 1'b1;
    wait_edge(108); reset = 1'b1;
    wait_edge(109);
    check("midrst_held_0", btnL_held, 1'b0);
    wait_edge(110);
    check("midrst_held_1", btnL_held, 1'b0);
    reset = 1'b0;
    q_left.push_back(111 + LAT);
    wait_edge(116);
    check("midrst_not_yet", btnL_held, 1'b0);
    wait_edge(117);
    check("midrst_held_after", btnL_held, 1'b1);
    wait_edge(120); btnL_raw = 1'b0;

    // Hold right for 40 samples (edges 131..170).
    wait_edge(130);
    btnR_raw = 1'b1;
    q_right.push_back(131 + LAT);
`ifdef BTN_REPEAT_EN
    for (int t = 131 + LAT + RDELAY; t <= 131 + 41; t += RPER) q_right.push_back(t);
`endif
    wait_edge(170);
    check("hold_right_held", btnR_held, 1'b1);
    btnR_raw = 1'b0;
    wait_edge(185);
    check("hold_right_released", btnR_held, 1'b0);

    check("left_queue_drained", q_left.size() == 0, 1'b1);
    check("right_queue_drained", q_right.size() == 0, 1'b1);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_btn_pulse_conditioner
